// File: rtl/bcd_pkg.sv
// Shared BCD digit type, width and clamp helper for the two-digit counter.
// No logic of its own: constants, typedef and one pure function.
// No flow control: consumers use these in combinational context.
package bcd_pkg;
    localparam int BCD_W = 4;
    typedef logic [BCD_W-1:0] bcd_t;
    localparam bcd_t BCD_MAX = 4'd9;

    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register that steps up/down between 0 and max_dig, or loads.
// Latency: digit updates one edge after step/load; cout is combinational from state+step.
// No backpressure: step and load are single-cycle strobes, load wins over step.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic step,
    input  logic up_dn,
    input  logic load,
    input  bcd_t load_dig,
    input  bcd_t max_dig,
    output bcd_t digit,
    output logic cout
);
    bcd_t digit_d, digit_q;
    logic at_edge;

    always_comb begin
        at_edge = up_dn ? (digit_q == max_dig) : (digit_q == '0);
        cout    = step && at_edge;
        digit_d = digit_q;
        if (load) begin
            digit_d = load_dig;
        end else if (step) begin
            if (up_dn) digit_d = at_edge ? bcd_t'(0) : digit_q + bcd_t'(1);
            else       digit_d = at_edge ? max_dig   : digit_q - bcd_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) digit_q <= '0;
        else        digit_q <= digit_d;
    end

    assign digit = digit_q;
endmodule

// File: rtl/bcd_two_digit_counter.sv
// Two-digit BCD up/down counter with prescaler, clamped load and tc pulse; BCD_CNT_SATURATE_EN holds at limits.
// Latency: tens/ones/tc change one edge after a tick or load; all outputs registered.
// No backpressure: en freezes prescaler and count, load overrides en and tick.
module bcd_two_digit_counter
    import bcd_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int MAX_TENS = 9,
    parameter int MAX_ONES = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up_dn,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       tc
);
    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam bcd_t          TOP_T      = bcd_t'(MAX_TENS);
    localparam bcd_t          TOP_O      = bcd_t'(MAX_ONES);

    logic [PW-1:0] presc_d, presc_q;
    logic          tc_d, tc_q;
    logic          tick, at_limit, step_ones, dig_load;
    logic          carry_ones, tens_cout_unused;
    bcd_t          tens_q, ones_q, clamp_t, clamp_o, ld_t, ld_o;

    always_comb begin
        tick     = en && (presc_q == PRESC_LAST);
        at_limit = up_dn ? (tens_q == TOP_T && ones_q == TOP_O)
                         : (tens_q == '0 && ones_q == '0);

        presc_d = presc_q;
        if (load)    presc_d = '0;
        else if (en) presc_d = tick ? '0 : presc_q + 1'b1;

        // BCD digit order matches numeric order, so one 8-bit compare clamps to the top value
        clamp_t = bcd_clamp(load_val[7:4]);
        clamp_o = bcd_clamp(load_val[3:0]);
        if ({clamp_t, clamp_o} > {TOP_T, TOP_O}) begin
            clamp_t = TOP_T;
            clamp_o = TOP_O;
        end

        step_ones = tick && !at_limit && !load;
`ifdef BCD_CNT_SATURATE_EN
        dig_load = load;
        ld_t     = clamp_t;
        ld_o     = clamp_o;
        tc_d     = tick && at_limit && !load;
`else
        // Wrap reuses the digits' load path so the top value need not be a digit boundary
        dig_load = load || (tick && at_limit);
        ld_t     = load ? clamp_t : (up_dn ? bcd_t'(0) : TOP_T);
        ld_o     = load ? clamp_o : (up_dn ? bcd_t'(0) : TOP_O);
        tc_d     = tick && at_limit && !load;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tc_q    <= tc_d;
        end
    end

    bcd_digit u_ones (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (step_ones),
        .up_dn    (up_dn),
        .load     (dig_load),
        .load_dig (ld_o),
        .max_dig  (BCD_MAX),
        .digit    (ones_q),
        .cout     (carry_ones)
    );

    bcd_digit u_tens (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (carry_ones),
        .up_dn    (up_dn),
        .load     (dig_load),
        .load_dig (ld_t),
        .max_dig  (TOP_T),
        .digit    (tens_q),
        .cout     (tens_cout_unused)
    );

    assign tens = tens_q;
    assign ones = ones_q;
    assign tc   = tc_q;
endmodule

// File: tb/tb_bcd_two_digit_counter.sv
// Bench for bcd_two_digit_counter: two instances (top 99 and top 59) against an integer reference model.
module tb_bcd_two_digit_counter;
    localparam int TICK_DIV = 4;
`ifdef BCD_CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, en, up_dn, load;
    logic [7:0] load_val;
    logic [3:0] tens_a, ones_a, tens_b, ones_b;
    logic       tc_a, tc_b;

    int   checks   = 0;
    int   failures = 0;
    int   mn [2];
    int   mp;
    logic mtc [2];

    always #5 clk = ~clk;

    bcd_two_digit_counter #(.TICK_DIV(TICK_DIV), .MAX_TENS(9), .MAX_ONES(9)) u99 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .tens(tens_a), .ones(ones_a), .tc(tc_a)
    );

    bcd_two_digit_counter #(.TICK_DIV(TICK_DIV), .MAX_TENS(5), .MAX_ONES(9)) u59 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .tens(tens_b), .ones(ones_b), .tc(tc_b)
    );

    // ---------------- reference model: count held as an integer 0..top ----------------
    function automatic int top_of(input int i);
        return (i == 0) ? 99 : 59;
    endfunction

    function automatic int load_model(input logic [7:0] lv, input int top);
        int t, o, v;
        t = int'(lv[7:4]);
        o = int'(lv[3:0]);
        if (t > 9) t = 9;
        if (o > 9) o = 9;
        v = t * 10 + o;
        return (v > top) ? top : v;
    endfunction

    function automatic int next_model(input int n, input logic up, input int top);
        if (up)  return (n == top) ? (SAT ? top : 0) : n + 1;
        else     return (n == 0)   ? (SAT ? 0 : top) : n - 1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mp <= 0;
            for (int i = 0; i < 2; i++) begin mn[i] <= 0; mtc[i] <= 1'b0; end
        end else if (load) begin
            mp <= 0;
            for (int i = 0; i < 2; i++) begin mn[i] <= load_model(load_val, top_of(i)); mtc[i] <= 1'b0; end
        end else if (en && mp == TICK_DIV - 1) begin
            mp <= 0;
            for (int i = 0; i < 2; i++) begin
                mn[i]  <= next_model(mn[i], up_dn, top_of(i));
                mtc[i] <= up_dn ? (mn[i] == top_of(i)) : (mn[i] == 0);
            end
        end else begin
            if (en) mp <= mp + 1;
            for (int i = 0; i < 2; i++) mtc[i] <= 1'b0;
        end
    end

    function automatic logic [8:0] exp_of(input int i);
        return {4'(mn[i] / 10), 4'(mn[i] % 10), mtc[i]};
    endfunction

    function automatic logic [8:0] obs(input int i);
        return (i == 0) ? {tens_a, ones_a, tc_a} : {tens_b, ones_b, tc_b};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; load = 1'b1; load_val = 8'h55; up_dn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({tens_a, ones_a, tc_a} !== 9'h000) begin
                failures++; $display("FAIL reset_state got %h required 000", {tens_a, ones_a, tc_a});
            end
        end
        rst_n = 1'b1; load = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== exp_of(i)) begin
                    failures++; $display("FAIL reset_release inst%0d cyc%0d got %h required %h", i, c, obs(i), exp_of(i));
                end
            end
            if (c == 2 || c == 3) begin
                checks++;
                if ({tens_a, ones_a} !== ((c == 3) ? 8'h01 : 8'h00)) begin
                    failures++; $display("FAIL first_step cyc%0d got %h required %h", c, {tens_a, ones_a}, (c == 3) ? 8'h01 : 8'h00);
                end
            end
        end
    endtask

    task automatic test_up_rollover();
        logic [7:0] vals [2];
        vals[0] = 8'h97; vals[1] = 8'h09;
        for (int k = 0; k < 2; k++) begin
            load = 1'b1; load_val = vals[k]; up_dn = 1'b1; en = 1'b1;
            for (int c = 0; c < 13; c++) begin
                @(negedge clk);
                load = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (obs(i) !== exp_of(i)) begin
                        failures++; $display("FAIL up_count inst%0d cyc%0d got %h required %h", i, c, obs(i), exp_of(i));
                    end
                end
                if (k == 0 && c == 12) begin
                    checks++;
                    if ({tens_a, ones_a, tc_a} !== (SAT ? {8'h99, 1'b1} : {8'h00, 1'b1})) begin
                        failures++; $display("FAIL up_wrap got %h required %h", {tens_a, ones_a, tc_a}, SAT ? {8'h99, 1'b1} : {8'h00, 1'b1});
                    end
                end
                if (k == 1 && c == 4) begin
                    checks++;
                    if ({tens_a, ones_a} !== 8'h10) begin
                        failures++; $display("FAIL carry_09_10 got %h required 10", {tens_a, ones_a});
                    end
                end
            end
        end
    endtask

    task automatic test_down_wrap();
        logic [7:0] vals [2];
        vals[0] = 8'h01; vals[1] = 8'h50;
        for (int k = 0; k < 2; k++) begin
            load = 1'b1; load_val = vals[k]; up_dn = 1'b0; en = 1'b1;
            for (int c = 0; c < 9; c++) begin
                @(negedge clk);
                load = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (obs(i) !== exp_of(i)) begin
                        failures++; $display("FAIL down_count inst%0d cyc%0d got %h required %h", i, c, obs(i), exp_of(i));
                    end
                end
                if (k == 0 && c == 8) begin
                    checks++;
                    if ({tens_b, ones_b, tc_b} !== (SAT ? {8'h00, 1'b1} : {8'h59, 1'b1})) begin
                        failures++; $display("FAIL down_wrap59 got %h required %h", {tens_b, ones_b, tc_b}, SAT ? {8'h00, 1'b1} : {8'h59, 1'b1});
                    end
                end
                if (k == 1 && c == 4) begin
                    checks++;
                    if ({tens_b, ones_b} !== 8'h49) begin
                        failures++; $display("FAIL borrow_50_49 got %h required 49", {tens_b, ones_b});
                    end
                end
            end
        end
    endtask

    task automatic test_load_clamp();
        logic [7:0] vals [3];
        logic [15:0] want [3];
        vals[0] = 8'hAF; want[0] = 16'h9959;
        vals[1] = 8'h75; want[1] = 16'h7559;
        vals[2] = 8'h42; want[2] = 16'h4242;
        up_dn = 1'b1; en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            load = 1'b1; load_val = vals[k];
            if (k == 2) en = 1'b0;
            @(negedge clk);
            load = 1'b0;
            checks++;
            if ({tens_a, ones_a, tens_b, ones_b} !== want[k]) begin
                failures++; $display("FAIL load_clamp val=%h got %h required %h", vals[k], {tens_a, ones_a, tens_b, ones_b}, want[k]);
            end
            if (k == 1) begin
                en = 1'b1;
                repeat (2) @(negedge clk);
            end
        end
        for (int c = 0; c < 6; c++) begin
            if (c == 2) en = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== exp_of(i)) begin
                    failures++; $display("FAIL load_restart inst%0d cyc%0d got %h required %h", i, c, obs(i), exp_of(i));
                end
            end
            if (c == 4 || c == 5) begin
                checks++;
                if ({tens_a, ones_a} !== ((c == 5) ? 8'h43 : 8'h42)) begin
                    failures++; $display("FAIL presc_restart cyc%0d got %h required %h", c, {tens_a, ones_a}, (c == 5) ? 8'h43 : 8'h42);
                end
            end
        end
    endtask

    task automatic test_enable_freeze();
        load = 1'b1; load_val = 8'h20; up_dn = 1'b1; en = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c == 3)  en = 1'b0;
            if (c == 13) en = 1'b1;
            @(negedge clk);
            load = 1'b0;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== exp_of(i)) begin
                    failures++; $display("FAIL freeze inst%0d cyc%0d got %h required %h", i, c, obs(i), exp_of(i));
                end
            end
            if (c == 13 || c == 14) begin
                checks++;
                if ({tens_a, ones_a} !== ((c == 14) ? 8'h21 : 8'h20)) begin
                    failures++; $display("FAIL resume_step cyc%0d got %h required %h", c, {tens_a, ones_a}, (c == 14) ? 8'h21 : 8'h20);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            load     = ($urandom_range(0, 24) == 0);
            load_val = 8'($urandom);
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) up_dn = ~up_dn;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== exp_of(i)) begin
                    failures++; $display("FAIL random inst%0d cyc%0d got %h required %h", i, c, obs(i), exp_of(i));
                end
            end
        end
        rst_n = 1'b1; load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;
        @(negedge clk);
        test_reset();
        test_up_rollover();
        test_down_wrap();
        test_load_clamp();
        test_enable_freeze();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
